// File: rtl/traffic_intersection_model.sv
// Road-side model of a two-street intersection: per-street car queues fed by arrival
// pulses and drained on green. Optional light-protocol checker behind LIGHT_CHECK_EN.
module traffic_intersection_model #(
  parameter int QW            = 4,
  parameter int DEPART_CYCLES = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          car_a,
  input  logic          car_b,
  input  logic [2:0]    La,
  input  logic [2:0]    Lb,
  output logic          sa,
  output logic          sb,
  output logic [QW-1:0] count_a,
  output logic [QW-1:0] count_b,
  output logic          ovf,
  output logic          err,
  output logic [1:0]    err_cause
);

  localparam logic [2:0] GREEN  = 3'b011;
  localparam logic [2:0] YELLOW = 3'b001;
  localparam logic [2:0] RED    = 3'b111;
  localparam int TW = (DEPART_CYCLES > 1) ? $clog2(DEPART_CYCLES) : 1;
  localparam logic [TW-1:0] TC   = TW'(DEPART_CYCLES - 1);
  localparam logic [QW-1:0] QMAX = '1;

  logic [TW-1:0] timer_a, timer_b, timer_a_nxt, timer_b_nxt;
  logic [QW-1:0] count_a_nxt, count_b_nxt;
  logic          dep_a, dep_b, drop_a, drop_b;

  // Departure timers count consecutive green edges and fire on the terminal count.
  always_comb begin
    timer_a_nxt = '0;
    timer_b_nxt = '0;
    dep_a       = 1'b0;
    dep_b       = 1'b0;
    if (La == GREEN) begin
      if (timer_a == TC) dep_a = (count_a != '0);
      else               timer_a_nxt = timer_a + 1'b1;
    end
    if (Lb == GREEN) begin
      if (timer_b == TC) dep_b = (count_b != '0);
      else               timer_b_nxt = timer_b + 1'b1;
    end
  end

  always_comb begin
    count_a_nxt = count_a;
    count_b_nxt = count_b;
    drop_a      = 1'b0;
    drop_b      = 1'b0;
    if (car_a && !dep_a) begin
      if (count_a == QMAX) drop_a = 1'b1;
      else                 count_a_nxt = count_a + 1'b1;
    end else if (!car_a && dep_a) begin
      count_a_nxt = count_a - 1'b1;
    end
    if (car_b && !dep_b) begin
      if (count_b == QMAX) drop_b = 1'b1;
      else                 count_b_nxt = count_b + 1'b1;
    end else if (!car_b && dep_b) begin
      count_b_nxt = count_b - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer_a <= '0;
      timer_b <= '0;
      count_a <= '0;
      count_b <= '0;
      ovf     <= 1'b0;
    end else begin
      timer_a <= timer_a_nxt;
      timer_b <= timer_b_nxt;
      count_a <= count_a_nxt;
      count_b <= count_b_nxt;
      ovf     <= ovf | drop_a | drop_b;
    end
  end

  assign sa = (count_a != '0);
  assign sb = (count_b != '0);

`ifdef LIGHT_CHECK_EN
  logic [2:0] la_prev, lb_prev;
  logic [1:0] cause;
  logic       legal_a, legal_b;

  assign legal_a = (La == GREEN) || (La == YELLOW) || (La == RED);
  assign legal_b = (Lb == GREEN) || (Lb == YELLOW) || (Lb == RED);

  always_comb begin
    cause = 2'b00;
    if (!legal_a || !legal_b)
      cause = 2'b01;
    else if (La != RED && Lb != RED)
      cause = 2'b10;
    else if ((la_prev == GREEN && La == RED) || (lb_prev == GREEN && Lb == RED))
      cause = 2'b11;
  end

  // Only the first cause is latched; later violations leave err_cause untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err       <= 1'b0;
      err_cause <= 2'b00;
      la_prev   <= RED;
      lb_prev   <= RED;
    end else begin
      la_prev <= La;
      lb_prev <= Lb;
      if (!err && cause != 2'b00) begin
        err       <= 1'b1;
        err_cause <= cause;
      end
    end
  end
`else
  assign err       = 1'b0;
  assign err_cause = 2'b00;
`endif

endmodule

// File: tb/tb_traffic_intersection_model.sv
// Randomized self-checking bench for traffic_intersection_model against a
// queue/run-length reference model; light checking tested when LIGHT_CHECK_EN is set.
module tb_traffic_intersection_model;

  localparam int QW   = 4;
  localparam int DC   = 2;
  localparam int QMAX = (1 << QW) - 1;
  localparam logic [2:0] G = 3'b011;
  localparam logic [2:0] Y = 3'b001;
  localparam logic [2:0] R = 3'b111;

  logic          clk = 1'b0;
  logic          reset;
  logic          car_a, car_b;
  logic [2:0]    La, Lb;
  logic          sa, sb, ovf, err;
  logic [QW-1:0] count_a, count_b;
  logic [1:0]    err_cause;

  int checks   = 0;
  int failures = 0;

  // reference model state
  int         ma, mb;     // queued cars
  int         ga, gb;     // length of current green run
  bit         movf, merr;
  logic [1:0] mcause;
  logic [2:0] pa, pb;

  traffic_intersection_model #(.QW(QW), .DEPART_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .car_a(car_a), .car_b(car_b), .La(La), .Lb(Lb),
    .sa(sa), .sb(sb), .count_a(count_a), .count_b(count_b),
    .ovf(ovf), .err(err), .err_cause(err_cause)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit legal(logic [2:0] l);
    return (l == G) || (l == Y) || (l == R);
  endfunction

  task automatic model_reset();
    ma = 0; mb = 0; ga = 0; gb = 0;
    movf = 0; merr = 0; mcause = 2'b00;
    pa = R; pb = R;
  endtask

  task automatic model_edge(input bit a, input bit b, input logic [2:0] la, input logic [2:0] lb);
    bit da, db;
    logic [1:0] c;
    da = 0; db = 0;
    if (la == G) begin ga++; da = (ga % DC == 0) && (ma > 0); end else ga = 0;
    if (lb == G) begin gb++; db = (gb % DC == 0) && (mb > 0); end else gb = 0;
    if (a && !da) begin if (ma == QMAX) movf = 1; else ma++; end
    else if (!a && da) ma--;
    if (b && !db) begin if (mb == QMAX) movf = 1; else mb++; end
    else if (!b && db) mb--;
`ifdef LIGHT_CHECK_EN
    c = 2'b00;
    if (!legal(la) || !legal(lb)) c = 2'b01;
    else if (la != R && lb != R) c = 2'b10;
    else if ((pa == G && la == R) || (pb == G && lb == R)) c = 2'b11;
    if (!merr && c != 2'b00) begin merr = 1; mcause = c; end
    pa = la; pb = lb;
`else
    c = 2'b00;
`endif
  endtask

  task automatic check_all(input string tag);
    check({tag, ".count_a"}, 32'(count_a), 32'(ma));
    check({tag, ".count_b"}, 32'(count_b), 32'(mb));
    check({tag, ".sa"}, 32'(sa), 32'(ma != 0));
    check({tag, ".sb"}, 32'(sb), 32'(mb != 0));
    check({tag, ".ovf"}, 32'(ovf), 32'(movf));
    check({tag, ".err"}, 32'(err), 32'(merr));
    check({tag, ".err_cause"}, 32'(err_cause), 32'(mcause));
  endtask

  // inputs change 1 time unit after a rising edge; outputs sampled 1 unit after the next
  task automatic step(input bit a, input bit b, input logic [2:0] la, input logic [2:0] lb,
                      input string tag);
    car_a = a; car_b = b; La = la; Lb = lb;
    @(posedge clk);
    model_edge(a, b, la, lb);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    car_a = 0; car_b = 0; La = R; Lb = R;
    #2;
    model_reset();
    check_all("reset");
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  function automatic logic [2:0] pick_light();
    int r;
    r = $urandom_range(0, 15);
    if (r < 6)  return G;
    if (r < 9)  return Y;
    if (r < 15) return R;
    return 3'($urandom_range(0, 7));
  endfunction

  initial begin
    logic [2:0] la, lb;
    int len;
    reset = 1'b0; car_a = 0; car_b = 0; La = R; Lb = R;
    model_reset();
    #1;
    check_all("por");
    @(posedge clk);
    #1;
    reset = 1'b1;

    // arrivals on red
    for (int i = 0; i < 3; i++) step(1, 0, R, R, "arr_red");
    check("arr_red.final", 32'(count_a), 32'd3);

    // drain on green: departures every DC edges
    for (int i = 0; i < 7; i++) step(0, 0, G, R, "drain");
    check("drain.final", 32'(count_a), 32'd0);

    // arrival on departure edge, and timer restart after yellow
    do_reset();
    step(0, 1, R, R, "b_arr");
    step(0, 0, R, G, "b_g1");
    step(0, 1, R, G, "b_g2");
    check("b_hold", 32'(count_b), 32'd1);
    do_reset();
    step(1, 0, R, R, "a_arr");
    step(1, 0, R, R, "a_arr");
    step(0, 0, G, R, "a_g1");
    step(0, 0, Y, R, "a_y");
    step(0, 0, G, R, "a_g1b");
    check("a_restart", 32'(count_a), 32'd2);
    step(0, 0, G, R, "a_g2b");
    check("a_dep", 32'(count_a), 32'd1);

    // saturation and sticky overflow
    do_reset();
    for (int i = 0; i < 16; i++) step(1, 0, R, R, "sat");
    check("sat.count", 32'(count_a), 32'(QMAX));
    check("sat.ovf", 32'(ovf), 32'd1);
    for (int i = 0; i < 10; i++) step(0, 0, G, R, "sat_drain");
    check("sat.ovf_sticky", 32'(ovf), 32'd1);

    // asynchronous reset mid-drain
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 0, R, R, "pre_async");
    step(1, 1, G, G, "pre_async_g");
    step(0, 0, G, R, "pre_async_g2");
    reset = 1'b0;
    #2;
    model_reset();
    check("async.count_a", 32'(count_a), 32'd0);
    check("async.sa", 32'(sa), 32'd0);
    check("async.ovf", 32'(ovf), 32'd0);
    check("async.err", 32'(err), 32'd0);
    car_a = 1;
    @(posedge clk);
    #1;
    check("async.ignore_arr", 32'(count_a), 32'd0);
    reset = 1'b1;
    car_a = 0;

`ifdef LIGHT_CHECK_EN
    do_reset();
    step(0, 0, G, Y, "chk_both");
    check("chk_both.cause", 32'(err_cause), 32'd2);
    step(0, 0, 3'b000, R, "chk_keep");
    check("chk_keep.cause", 32'(err_cause), 32'd2);
    do_reset();
    step(0, 0, G, R, "chk_gr1");
    step(0, 0, R, R, "chk_gr2");
    check("chk_gr.cause", 32'(err_cause), 32'd3);
    do_reset();
    step(0, 0, 3'b010, R, "chk_ill");
    check("chk_ill.cause", 32'(err_cause), 32'd1);
`endif

    // randomized phases
    do_reset();
    for (int p = 0; p < 300; p++) begin
      la  = pick_light();
      lb  = pick_light();
      len = $urandom_range(1, 8);
      for (int k = 0; k < len; k++)
        step($urandom_range(0, 9) < 4, $urandom_range(0, 9) < 4, la, lb, "rand");
      if (p % 100 == 99) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
